// File: rtl/serial_subtractor4_pkg.sv
// Shared types for the bit-serial 4-bit subtractor.
// SERIAL_SUB_OVERFLOW_EN adds the signed-overflow output.
package serial_subtractor4_pkg;

  localparam int WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef logic [1:0] cnt_t;

  localparam cnt_t CNT_LAST = cnt_t'(WIDTH - 1);

endpackage

// File: rtl/serial_subtractor4_full_subtractor.sv
// Single-bit full subtractor cell: d = a - b - bin.
// Purely combinational; one instance serves every bit position.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor4.sv
// Bit-serial 4-bit subtractor, LSB first, valid/ready on both sides.
// Define SERIAL_SUB_OVERFLOW_EN to add the io_overflow output.
module serial_subtractor4
  import serial_subtractor4_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_valid,
  output logic             io_in_ready,
  input  logic [WIDTH-1:0] io_a,
  input  logic [WIDTH-1:0] io_b,
  input  logic             io_borrowIn,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_diff,
`ifdef SERIAL_SUB_OVERFLOW_EN
  output logic             io_overflow,
`endif
  output logic             io_borrowOut
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  cnt_t             cnt_q, cnt_d;
  logic             fs_d;
  logic             fs_bout;

  full_subtractor u_fs (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .bin  (borrow_q),
    .d    (fs_d),
    .bout (fs_bout)
  );

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic ovf_q, ovf_d;
`endif

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    diff_d   = diff_q;
    borrow_d = borrow_q;
    cnt_d    = cnt_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (io_in_valid) begin
          a_d      = io_a;
          b_d      = io_b;
          borrow_d = io_borrowIn;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        a_d      = a_q >> 1;
        b_d      = b_q >> 1;
        borrow_d = fs_bout;
        diff_d   = {fs_d, diff_q[WIDTH-1:1]};
        cnt_d    = cnt_q + cnt_t'(1);
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
`ifdef SERIAL_SUB_OVERFLOW_EN
          // shift LSBs now hold the original operand MSBs
          ovf_d = (a_q[0] ^ b_q[0]) & (fs_d ^ a_q[0]);
`endif
        end
      end
      DONE: begin
        if (io_out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      diff_q   <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      diff_q   <= diff_d;
      borrow_q <= borrow_d;
      cnt_q    <= cnt_d;
`ifdef SERIAL_SUB_OVERFLOW_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign io_in_ready  = (state_q == IDLE);
  assign io_out_valid = (state_q == DONE);
  assign io_diff      = diff_q;
  assign io_borrowOut = borrow_q;
`ifdef SERIAL_SUB_OVERFLOW_EN
  assign io_overflow  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor4.sv
// Self-checking bench for serial_subtractor4 against an arithmetic model.
// Covers SERIAL_SUB_OVERFLOW_EN when the macro is defined.
module tb_serial_subtractor4;

  logic       clock;
  logic       reset;
  logic       io_in_valid;
  logic       io_in_ready;
  logic [3:0] io_a;
  logic [3:0] io_b;
  logic       io_borrowIn;
  logic       io_out_valid;
  logic       io_out_ready;
  logic [3:0] io_diff;
  logic       io_borrowOut;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic       io_overflow;
`endif

  int tests_run;
  int tests_failed;
  logic last_ovf;

  serial_subtractor4 dut (
    .clock        (clock),
    .reset        (reset),
    .io_in_valid  (io_in_valid),
    .io_in_ready  (io_in_ready),
    .io_a         (io_a),
    .io_b         (io_b),
    .io_borrowIn  (io_borrowIn),
    .io_out_valid (io_out_valid),
    .io_out_ready (io_out_ready),
    .io_diff      (io_diff),
`ifdef SERIAL_SUB_OVERFLOW_EN
    .io_overflow  (io_overflow),
`endif
    .io_borrowOut (io_borrowOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] ref_diff(input int a, input int b,
                                          input int bin);
    int r;
    r = a - b - bin;
    return 4'((r % 16 + 16) % 16);
  endfunction

  function automatic logic ref_borrow(input int a, input int b, input int bin);
    return a < (b + bin);
  endfunction

  function automatic logic ref_ovf(input int a, input int b);
    int sa, sb, r;
    sa = (a >= 8) ? a - 16 : a;
    sb = (b >= 8) ? b - 16 : b;
    r  = sa - sb;
    return (r > 7) || (r < -8);
  endfunction

  // Issue one input handshake; wait for out_valid; leave it pending.
  task automatic start_and_wait(input logic [3:0] a, input logic [3:0] b,
                                input logic bin, output int lat);
    int n;
    n = 0;
    @(negedge clock);
    while (!io_in_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    io_a = a;
    io_b = b;
    io_borrowIn = bin;
    io_in_valid = 1'b1;
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    io_a = 4'($urandom);
    io_b = 4'($urandom);
    io_borrowIn = 1'($urandom);
    lat = 0;
    while (!io_out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    if (!io_out_valid) lat = -1;
  endtask

  task automatic consume();
    @(negedge clock);
    io_out_ready = 1'b1;
    @(posedge clock);
    #1;
    io_out_ready = 1'b0;
  endtask

  task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                        input logic bin, output logic [3:0] d,
                        output logic bo, output int lat);
    start_and_wait(a, b, bin, lat);
    d  = io_diff;
    bo = io_borrowOut;
`ifdef SERIAL_SUB_OVERFLOW_EN
    last_ovf = io_overflow;
`else
    last_ovf = 1'b0;
`endif
    consume();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    tests_run++;
    if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0 ||
        io_diff !== 4'd0 || io_borrowOut !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset: rdy=%b vld=%b diff=%0d bo=%b, want 1 0 0 0",
               io_in_ready, io_out_valid, io_diff, io_borrowOut);
    end
`ifdef SERIAL_SUB_OVERFLOW_EN
    tests_run++;
    if (io_overflow !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ovf: got %b want 0", io_overflow);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0] d;
    logic bo;
    int lat;
    int va[3] = '{7, 3, 0};
    int vb[3] = '{3, 7, 0};
    int vc[3] = '{0, 0, 1};
    int ed[3] = '{4, 12, 15};
    int eb[3] = '{0, 1, 1};
    for (int i = 0; i < 3; i++) begin
      run_op(4'(va[i]), 4'(vb[i]), 1'(vc[i]), d, bo, lat);
      tests_run++;
      if (lat !== 4) begin
        tests_failed++;
        $display("FAIL latency_%0d: got %0d want 4", i, lat);
      end
      tests_run++;
      if (d !== 4'(ed[i]) || bo !== 1'(eb[i])) begin
        tests_failed++;
        $display("FAIL directed_%0d: diff=%0d bo=%b want %0d %0d",
                 i, d, bo, ed[i], eb[i]);
      end
    end
  endtask

  task automatic test_exhaustive();
    logic [3:0] d;
    logic bo;
    int lat;
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++) begin
          run_op(4'(a), 4'(b), 1'(c), d, bo, lat);
          tests_run++;
          if (lat !== 4 || d !== ref_diff(a, b, c) ||
              bo !== ref_borrow(a, b, c)) begin
            tests_failed++;
            $display("FAIL sweep a=%0d b=%0d c=%0d: diff=%0d bo=%b lat=%0d want %0d %b 4",
                     a, b, c, d, bo, lat, ref_diff(a, b, c),
                     ref_borrow(a, b, c));
          end
        end
  endtask

  task automatic test_backpressure();
    int lat;
    logic [3:0] ed;
    logic eb;
    ed = ref_diff(11, 6, 1);
    eb = ref_borrow(11, 6, 1);
    start_and_wait(4'd11, 4'd6, 1'b1, lat);
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (io_out_valid !== 1'b1 || io_in_ready !== 1'b0 ||
          io_diff !== ed || io_borrowOut !== eb) begin
        tests_failed++;
        $display("FAIL backpressure_%0d: vld=%b rdy=%b diff=%0d bo=%b want 1 0 %0d %b",
                 k, io_out_valid, io_in_ready, io_diff, io_borrowOut, ed, eb);
      end
      @(posedge clock);
      #1;
    end
    consume();
    tests_run++;
    if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL after_consume: rdy=%b vld=%b want 1 0",
               io_in_ready, io_out_valid);
    end
  endtask

  task automatic test_busy_ignore();
    int lat;
    logic [3:0] d;
    @(negedge clock);
    io_a = 4'd13;
    io_b = 4'd2;
    io_borrowIn = 1'b0;
    io_in_valid = 1'b1;
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    @(negedge clock);
    io_a = 4'd1;
    io_b = 4'd9;
    io_borrowIn = 1'b1;
    io_in_valid = 1'b1;
    @(negedge clock);
    io_in_valid = 1'b0;
    lat = 0;
    while (!io_out_valid && lat < 20) begin
      @(posedge clock);
      #1;
      lat++;
    end
    d = io_diff;
    tests_run++;
    if (!io_out_valid || d !== ref_diff(13, 2, 0) || io_borrowOut !== 1'b0) begin
      tests_failed++;
      $display("FAIL busy_ignore: vld=%b diff=%0d bo=%b want 1 11 0",
               io_out_valid, d, io_borrowOut);
    end
    consume();
    repeat (6) @(posedge clock);
    #1;
    tests_run++;
    if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL no_second_op: vld=%b rdy=%b want 0 1",
               io_out_valid, io_in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] d;
    logic bo;
    int lat;
    @(negedge clock);
    io_a = 4'd14;
    io_b = 4'd3;
    io_borrowIn = 1'b1;
    io_in_valid = 1'b1;
    @(posedge clock);
    #1;
    io_in_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b1;
    #1;
    tests_run++;
    if (io_out_valid !== 1'b0 || io_in_ready !== 1'b1 || io_diff !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_mid: vld=%b rdy=%b diff=%0d want 0 1 0",
               io_out_valid, io_in_ready, io_diff);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    tests_run++;
    if (io_out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_discard: vld=%b want 0", io_out_valid);
    end
    run_op(4'd9, 4'd4, 1'b0, d, bo, lat);
    tests_run++;
    if (d !== 4'd5 || bo !== 1'b0 || lat !== 4) begin
      tests_failed++;
      $display("FAIL after_reset_op: diff=%0d bo=%b lat=%0d want 5 0 4",
               d, bo, lat);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] d;
    logic bo;
    int lat, a, b, c;
    for (int i = 0; i < 40; i++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      c = int'($urandom_range(1, 0));
      run_op(4'(a), 4'(b), 1'(c), d, bo, lat);
      tests_run++;
      if (d !== ref_diff(a, b, c) || bo !== ref_borrow(a, b, c) ||
          io_in_ready !== 1'b1) begin
        tests_failed++;
        $display("FAIL b2b_%0d a=%0d b=%0d c=%0d: diff=%0d bo=%b rdy=%b want %0d %b 1",
                 i, a, b, c, d, bo, io_in_ready, ref_diff(a, b, c),
                 ref_borrow(a, b, c));
      end
    end
  endtask

`ifdef SERIAL_SUB_OVERFLOW_EN
  task automatic test_overflow();
    logic [3:0] d;
    logic bo;
    int lat, a, b, c;
    run_op(4'd8, 4'd1, 1'b0, d, bo, lat);
    tests_run++;
    if (d !== 4'd7 || last_ovf !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_8m1: diff=%0d ovf=%b want 7 1", d, last_ovf);
    end
    run_op(4'd5, 4'd2, 1'b0, d, bo, lat);
    tests_run++;
    if (d !== 4'd3 || last_ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL ovf_5m2: diff=%0d ovf=%b want 3 0", d, last_ovf);
    end
    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(15, 0));
      b = int'($urandom_range(15, 0));
      c = 0;
      run_op(4'(a), 4'(b), 1'(c), d, bo, lat);
      tests_run++;
      if (last_ovf !== ref_ovf(a, b)) begin
        tests_failed++;
        $display("FAIL ovf_rand a=%0d b=%0d: ovf=%b want %b",
                 a, b, last_ovf, ref_ovf(a, b));
      end
    end
  endtask
`endif

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    last_ovf     = 1'b0;
    reset        = 1'b1;
    io_in_valid  = 1'b0;
    io_out_ready = 1'b0;
    io_a         = '0;
    io_b         = '0;
    io_borrowIn  = 1'b0;
    test_reset();
    test_directed();
    test_exhaustive();
    test_backpressure();
    test_busy_ignore();
    test_reset_mid();
    test_back_to_back();
`ifdef SERIAL_SUB_OVERFLOW_EN
    test_overflow();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
